// File: rtl/wram_responder_pkg.sv
// Shared definitions for the weight-RAM responder: default widths, FIFO depth
// and the control FSM state encoding.
package wram_responder_pkg;

    localparam int WRAM_ADD_AW_DEF = 13;
    localparam int WRAM_DAT_DW_DEF = 8;
    localparam int STAT_CNT_DW_DEF = 16;

    // Read-response FIFO depth; in-flight RAM reads count against it too.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } wram_state_e;

endpackage

// File: rtl/wram_responder_sp.sv
// Single-port synchronous weight RAM. One access per cycle: a write or a
// registered read. Contents and the read register are deliberately not reset
// so the array maps onto block RAM.
module wram_sp #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write-or-read port; read data appears the cycle after the access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdat;
            end else begin
                rdat <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wram_responder.sv
// Weight-RAM responder: loads weights in LOAD mode, then serves read-address
// requests in SERVE mode through a 1-cycle RAM read and a 2-entry response
// FIFO, returning data in request order with the request's last flag.
module wram_responder
    import wram_responder_pkg::*;
#(
    parameter int WRAM_ADD_AW = WRAM_ADD_AW_DEF,
    parameter int WRAM_DAT_DW = WRAM_DAT_DW_DEF,
    parameter int STAT_CNT_DW = STAT_CNT_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   CFG_INFO_VLD,
    output logic                   CFG_INFO_RDY,
    input  logic                   CFG_MODE,
    input  logic                   WRAM_WR_VLD,
    output logic                   WRAM_WR_RDY,
    input  logic                   WRAM_WR_LST,
    input  logic [WRAM_ADD_AW-1:0] WRAM_WR_ADD,
    input  logic [WRAM_DAT_DW-1:0] WRAM_WR_DAT,
    input  logic                   WRAM_ADD_VLD,
    output logic                   WRAM_ADD_RDY,
    input  logic                   WRAM_ADD_LST,
    input  logic [WRAM_ADD_AW-1:0] WRAM_ADD_ADD,
    output logic                   WRAM_DAT_VLD,
    input  logic                   WRAM_DAT_RDY,
    output logic                   WRAM_DAT_LST,
    output logic [WRAM_DAT_DW-1:0] WRAM_DAT_DAT,
    output logic [STAT_CNT_DW-1:0] STAT_RD_CNT
);

    wram_state_e            state;
    logic                   lst_seen;
    logic [STAT_CNT_DW-1:0] rd_cnt;

    // RAM read issued last cycle; its data is on ram_rdat this cycle.
    logic                   infl_vld;
    logic                   infl_lst;
    logic [WRAM_DAT_DW-1:0] ram_rdat;

    logic [WRAM_DAT_DW-1:0] fifo_dat [0:1];
    logic                   fifo_lst [0:1];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_occ;
    logic [1:0]             pending;

    logic                   wr_hs;
    logic                   add_hs;
    logic                   dat_hs;

    logic                   ram_en;
    logic [WRAM_ADD_AW-1:0] ram_addr;

    assign CFG_INFO_RDY = (state == ST_IDLE);
    assign WRAM_WR_RDY  = (state == ST_LOAD);

    assign WRAM_DAT_VLD = (fifo_occ != 2'd0);
    assign WRAM_DAT_DAT = WRAM_DAT_VLD ? fifo_dat[rd_ptr] : '0;
    assign WRAM_DAT_LST = WRAM_DAT_VLD && fifo_lst[rd_ptr];

    assign wr_hs  = WRAM_WR_VLD && WRAM_WR_RDY;
    assign dat_hs = WRAM_DAT_VLD && WRAM_DAT_RDY;
    assign add_hs = WRAM_ADD_VLD && WRAM_ADD_RDY;

    // Occupancy plus the read in flight never exceeds the FIFO depth; a pop in
    // the same cycle frees the slot the new request will eventually need.
    assign pending      = fifo_occ + {1'b0, infl_vld};
    assign WRAM_ADD_RDY = (state == ST_SERVE) && !lst_seen &&
                          ((pending < FIFO_DEPTH) || dat_hs);

    // Writes only happen in LOAD and reads only in SERVE, so one port suffices.
    assign ram_en   = wr_hs || add_hs;
    assign ram_addr = wr_hs ? WRAM_WR_ADD : WRAM_ADD_ADD;

    wram_sp #(
        .AW (WRAM_ADD_AW),
        .DW (WRAM_DAT_DW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (wr_hs),
        .addr (ram_addr),
        .wdat (WRAM_WR_DAT),
        .rdat (ram_rdat)
    );

    assign STAT_RD_CNT = rd_cnt;

    // Mode FSM, end-of-stream tracking and saturating response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lst_seen <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CFG_INFO_VLD) begin
                        if (CFG_MODE) begin
                            state  <= ST_SERVE;
                            rd_cnt <= '0;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_hs && WRAM_WR_LST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (add_hs && WRAM_ADD_LST) begin
                        lst_seen <= 1'b1;
                    end
                    if (dat_hs && (rd_cnt != '1)) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    // The last response drains the pipeline, so nothing is
                    // left behind when returning to IDLE.
                    if (dat_hs && WRAM_DAT_LST) begin
                        state    <= ST_IDLE;
                        lst_seen <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pipeline control: in-flight flag, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_vld <= 1'b0;
            infl_lst <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_occ <= 2'd0;
        end else begin
            infl_vld <= add_hs;
            if (add_hs) begin
                infl_lst <= WRAM_ADD_LST;
            end
            if (infl_vld) begin
                wr_ptr <= ~wr_ptr;
            end
            if (dat_hs) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({infl_vld, dat_hs})
                2'b10:   fifo_occ <= fifo_occ + 2'd1;
                2'b01:   fifo_occ <= fifo_occ - 2'd1;
                default: fifo_occ <= fifo_occ;
            endcase
        end
    end

    // FIFO payload storage; validity is tracked by fifo_occ, so no reset.
    always_ff @(posedge clk) begin
        if (infl_vld) begin
            fifo_dat[wr_ptr] <= ram_rdat;
            fifo_lst[wr_ptr] <= infl_lst;
        end
    end

endmodule

// File: tb/tb_wram_responder.sv
// Self-checking bench for wram_responder: reset, LOAD, back-to-back SERVE,
// table-driven single reads, randomized SERVE against a queue model, and
// reset with responses pending.
module tb_wram_responder;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int NREQ = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_vld = 1'b0, cfg_mode = 1'b0;
    logic          wr_vld = 1'b0, wr_lst = 1'b0;
    logic [AW-1:0] wr_add = '0;
    logic [DW-1:0] wr_dat = '0;
    logic          add_vld = 1'b0, add_lst = 1'b0;
    logic [AW-1:0] add_add = '0;
    logic          dat_rdy = 1'b0;

    logic          cfg_rdy, wr_rdy, add_rdy, dat_vld, dat_lst;
    logic [DW-1:0] dat_dat;
    logic [CW-1:0] stat_cnt;

    logic          cfg_rdy2, wr_rdy2, add_rdy2, dat_vld2, dat_lst2;
    logic [DW-1:0] dat_dat2;
    logic [1:0]    stat2;

    always #5 clk = ~clk;

    wram_responder #(.WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW), .STAT_CNT_DW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .CFG_INFO_VLD(cfg_vld), .CFG_INFO_RDY(cfg_rdy), .CFG_MODE(cfg_mode),
        .WRAM_WR_VLD(wr_vld), .WRAM_WR_RDY(wr_rdy), .WRAM_WR_LST(wr_lst),
        .WRAM_WR_ADD(wr_add), .WRAM_WR_DAT(wr_dat),
        .WRAM_ADD_VLD(add_vld), .WRAM_ADD_RDY(add_rdy), .WRAM_ADD_LST(add_lst),
        .WRAM_ADD_ADD(add_add),
        .WRAM_DAT_VLD(dat_vld), .WRAM_DAT_RDY(dat_rdy), .WRAM_DAT_LST(dat_lst),
        .WRAM_DAT_DAT(dat_dat), .STAT_RD_CNT(stat_cnt)
    );

    // Narrow-counter instance used only to observe counter saturation.
    wram_responder #(.WRAM_ADD_AW(AW), .WRAM_DAT_DW(DW), .STAT_CNT_DW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .CFG_INFO_VLD(cfg_vld), .CFG_INFO_RDY(cfg_rdy2), .CFG_MODE(cfg_mode),
        .WRAM_WR_VLD(wr_vld), .WRAM_WR_RDY(wr_rdy2), .WRAM_WR_LST(wr_lst),
        .WRAM_WR_ADD(wr_add), .WRAM_WR_DAT(wr_dat),
        .WRAM_ADD_VLD(add_vld), .WRAM_ADD_RDY(add_rdy2), .WRAM_ADD_LST(add_lst),
        .WRAM_ADD_ADD(add_add),
        .WRAM_DAT_VLD(dat_vld2), .WRAM_DAT_RDY(dat_rdy), .WRAM_DAT_LST(dat_lst2),
        .WRAM_DAT_DAT(dat_dat2), .STAT_RD_CNT(stat2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and monitor ----------------
    typedef struct {
        logic [DW-1:0] d;
        bit            dv;
        logic          l;
        int            c;
    } exp_t;

    logic [DW-1:0] model_mem [int];
    exp_t          expq [$];
    int            sess_resp = 0;
    int            first_resp = -1;
    int            last_resp = -1;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            pv = 1'b0;
        end else begin
            if (cfg_vld && cfg_rdy) begin
                sess_resp  = 0;
                first_resp = -1;
                last_resp  = -1;
            end
            if (!dat_vld) chk("dat_zero_when_idle", {24'd0, dat_dat}, 32'd0);
            if (pv && !pr) begin
                chk("dat_vld_hold", {31'd0, dat_vld}, 32'd1);
                chk("dat_payload_hold", {23'd0, dat_lst, dat_dat}, {23'd0, pl, pd});
            end
            if (expq.size() >= 2 && !(dat_vld && dat_rdy))
                chk("add_rdy_low_when_full", {31'd0, add_rdy}, 32'd0);
            if (wr_vld && wr_rdy) model_mem[int'(wr_add)] = wr_dat;
            if (dat_vld && dat_rdy) begin
                chk("resp_expected", {31'd0, expq.size() != 0}, 32'd1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("resp_lst", {31'd0, dat_lst}, {31'd0, e.l});
                    if (e.dv) chk("resp_data", {24'd0, dat_dat}, {24'd0, e.d});
                    chk("resp_latency_min", {31'd0, (cyc - e.c) >= 2}, 32'd1);
                end
                $display("rsp %0d: dat=%02h lst=%0b cyc=%0d", sess_resp, dat_dat, dat_lst, cyc);
                if (first_resp < 0) first_resp = cyc;
                last_resp = cyc;
                sess_resp++;
            end
            if (add_vld && add_rdy) begin
                exp_t e;
                e.dv = model_mem.exists(int'(add_add));
                e.d  = e.dv ? model_mem[int'(add_add)] : '0;
                e.l  = add_lst;
                e.c  = cyc;
                expq.push_back(e);
            end
            pv = dat_vld; pr = dat_rdy; pd = dat_dat; pl = dat_lst;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_cfg(input logic mode);
        bit ok = 0;
        cfg_vld = 1'b1; cfg_mode = mode;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_rdy) begin ok = 1; break; end
            tick();
        end
        tick();
        cfg_vld = 1'b0;
        chk("cfg_hs_done", {31'd0, ok}, 32'd1);
        $display("cfg mode=%0d", mode);
    endtask

    task automatic send_add(input logic [AW-1:0] a, input logic l, output int acc, output bit ok);
        ok = 0; acc = 0;
        add_vld = 1'b1; add_add = a; add_lst = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (add_rdy) begin ok = 1; acc = cyc; break; end
            tick();
        end
        tick();
        add_vld = 1'b0; add_lst = 1'b0;
    endtask

    // One request with DAT_RDY held high; ends one cycle after the response.
    task automatic rd1(input logic [AW-1:0] a, input logic l, output logic [DW-1:0] d,
                       output logic dl, output int lat, output bit ok,
                       output logic rdy_after, output logic cfg_at_hs);
        int  acc;
        bit  got = 0;
        send_add(a, l, acc, ok);
        @(negedge clk);
        rdy_after = add_rdy;
        for (int i = 0; i < 10; i++) begin
            if (dat_vld) begin got = 1; break; end
            tick();
            @(negedge clk);
        end
        lat = cyc - acc; d = dat_dat; dl = dat_lst; cfg_at_hs = cfg_rdy;
        ok = ok && got;
        tick();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_rdy) begin ok = 1; break; end
            tick();
        end
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          lst;
        logic [DW-1:0] exp_d;
        logic          exp_l;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            lat, acc0, stalls, a, sent, wr_rdy_seen, acc;
        logic [DW-1:0] d;
        logic          dl, ra, ch, hs;

        vecs[0] = '{13'd3,    1'b0, 8'h59, 1'b0};
        vecs[1] = '{13'h40,   1'b0, 8'h1A, 1'b0};
        vecs[2] = '{13'h7F,   1'b0, 8'h25, 1'b0};
        vecs[3] = '{13'd0,    1'b0, 8'h5A, 1'b0};
        vecs[4] = '{13'd7,    1'b1, 8'h5D, 1'b1};

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dat_vld", {31'd0, dat_vld}, 32'd0);
        chk("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("rst_add_rdy", {31'd0, add_rdy}, 32'd0);
        chk("rst_stat", {16'd0, stat_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
        tick();

        // ---- LOAD 128 words ----
        do_cfg(1'b0);
        @(negedge clk);
        chk("load_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        chk("load_cfg_rdy", {31'd0, cfg_rdy}, 32'd0);
        tick();
        a = 0;
        for (int c = 0; c < 400 && a < 128; c++) begin
            wr_vld = 1'b1; wr_add = AW'(a); wr_dat = DW'(a) ^ 8'h5A; wr_lst = (a == 127);
            @(negedge clk);
            if (wr_rdy) a++;
            tick();
        end
        wr_vld = 1'b0; wr_lst = 1'b0;
        @(negedge clk);
        chk("load_words", a, 128);
        chk("load_idle_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
        chk("load_wr_rdy_off", {31'd0, wr_rdy}, 32'd0);
        tick();

        // ---- SERVE back-to-back ----
        dat_rdy = 1'b1;
        do_cfg(1'b1);
        a = 0; stalls = 0; acc0 = -1;
        for (int c = 0; c < 400 && a < 128; c++) begin
            add_vld = 1'b1; add_add = AW'(a); add_lst = (a == 127);
            @(negedge clk);
            if (add_rdy) begin
                if (a == 0) acc0 = cyc;
                a++;
            end else stalls++;
            tick();
        end
        add_vld = 1'b0; add_lst = 1'b0;
        wait_idle(ok);
        chk("b2b_idle", {31'd0, ok}, 32'd1);
        chk("b2b_sent", a, 128);
        chk("b2b_stalls", stalls, 0);
        chk("b2b_first_latency", first_resp - acc0, 2);
        chk("b2b_consecutive", last_resp - first_resp, 127);
        chk("b2b_resp_count", sess_resp, 128);
        chk("b2b_stat", {16'd0, stat_cnt}, 32'd128);
        chk("b2b_stat_saturate", {30'd0, stat2}, 32'd3);
        $display("b2b done: %0d responses", sess_resp);

        // ---- table-driven single reads ----
        do_cfg(1'b1);
        @(negedge clk);
        chk("stat_clear_on_serve", {16'd0, stat_cnt}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            rd1(vecs[i].addr, vecs[i].lst, d, dl, lat, ok, ra, ch);
            $display("vec %0d: addr=%0h dat=%02h lst=%0b lat=%0d", i, vecs[i].addr, d, dl, lat);
            chk("vec_done", {31'd0, ok}, 32'd1);
            chk("vec_latency", lat, 2);
            chk("vec_data", {24'd0, d}, {24'd0, vecs[i].exp_d});
            chk("vec_lst", {31'd0, dl}, {31'd0, vecs[i].exp_l});
            if (vecs[i].lst) begin
                chk("add_rdy_after_lst", {31'd0, ra}, 32'd0);
                chk("not_idle_at_lst_hs", {31'd0, ch}, 32'd0);
                @(negedge clk);
                chk("idle_after_lst_hs", {31'd0, cfg_rdy}, 32'd1);
                chk("table_stat", {16'd0, stat_cnt}, 32'd5);
                tick();
            end
        end

        // ---- randomized SERVE with stray writes ----
        do_cfg(1'b1);
        sent = 0; wr_rdy_seen = 0; ok = 0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            if (!add_vld && sent < NREQ && $urandom_range(0, 1) == 1) begin
                add_vld = 1'b1;
                add_add = AW'($urandom_range(0, 127));
                add_lst = (sent == NREQ - 1);
            end
            dat_rdy = ($urandom_range(0, 1) == 1);
            wr_vld  = 1'b1;
            wr_add  = AW'($urandom_range(0, 127));
            wr_dat  = DW'($urandom);
            @(negedge clk);
            hs = add_vld && add_rdy;
            if (wr_rdy) wr_rdy_seen++;
            if (cfg_rdy && sent == NREQ) ok = 1;
            tick();
            if (hs) begin
                sent++;
                add_vld = 1'b0; add_lst = 1'b0;
            end
        end
        wr_vld = 1'b0; dat_rdy = 1'b1;
        chk("rand_complete", {31'd0, ok}, 32'd1);
        chk("rand_resp_count", sess_resp, NREQ);
        chk("rand_stat", {16'd0, stat_cnt}, NREQ);
        chk("rand_queue_empty", expq.size(), 0);
        chk("wr_rdy_in_serve", wr_rdy_seen, 0);
        $display("random done: %0d requests", sent);

        // ---- reset with two responses pending ----
        dat_rdy = 1'b0;
        do_cfg(1'b1);
        send_add(13'd10, 1'b0, acc, ok);
        send_add(13'd11, 1'b0, acc, ok);
        tick(); tick();
        @(negedge clk);
        chk("pending_dat_vld", {31'd0, dat_vld}, 32'd1);
        chk("pending_add_rdy", {31'd0, add_rdy}, 32'd0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_dat_vld", {31'd0, dat_vld}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_dat_vld", {31'd0, dat_vld}, 32'd0);
        chk("post_rst_stat", {16'd0, stat_cnt}, 32'd0);
        chk("post_rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
        chk("post_rst_add_rdy", {31'd0, add_rdy}, 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("no_stale_dat_vld", {31'd0, dat_vld}, 32'd0);
        tick();
        dat_rdy = 1'b1;
        do_cfg(1'b1);
        rd1(13'd10, 1'b0, d, dl, lat, ok, ra, ch);
        chk("reread_10", {24'd0, d}, 32'h50);
        rd1(13'd11, 1'b0, d, dl, lat, ok, ra, ch);
        chk("reread_11", {24'd0, d}, 32'h51);
        rd1(13'd100, 1'b1, d, dl, lat, ok, ra, ch);
        chk("reread_100", {24'd0, d}, 32'h3E);
        chk("reread_lst", {31'd0, dl}, 32'd1);
        @(negedge clk);
        chk("reread_idle", {31'd0, cfg_rdy}, 32'd1);
        chk("reread_stat", {16'd0, stat_cnt}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wram_responder.md
WRAM_RESPONDER -- requirements
Module: wram_responder

Interface
REQ-001 Parameter WRAM_ADD_AW, default 13, read/write address width.
REQ-002 Parameter WRAM_DAT_DW, default 8, data width.
REQ-003 Parameter STAT_CNT_DW, default 16, read-count width.
REQ-004 clk  input  1  single clock; all flops on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 CFG_INFO_VLD / CFG_INFO_RDY  input/output  1/1  mode command handshake.
REQ-007 CFG_MODE  input  1  0 = LOAD, 1 = SERVE; sampled on CFG handshake.
REQ-008 WRAM_WR_VLD / WRAM_WR_RDY / WRAM_WR_LST  input/output/input  1/1/1  weight write handshake and last flag.
REQ-009 WRAM_WR_ADD / WRAM_WR_DAT  input  WRAM_ADD_AW / WRAM_DAT_DW  write address and data.
REQ-010 WRAM_ADD_VLD / WRAM_ADD_RDY / WRAM_ADD_LST  input/output/input  1/1/1  read-address request from WCA.
REQ-011 WRAM_ADD_ADD  input  WRAM_ADD_AW  read address.
REQ-012 WRAM_DAT_VLD / WRAM_DAT_RDY / WRAM_DAT_LST  output/input/output  1/1/1  read-data response to WCA.
REQ-013 WRAM_DAT_DAT  output  WRAM_DAT_DW  read data.
REQ-014 STAT_RD_CNT  output  STAT_CNT_DW  reads returned in current SERVE phase.

Function
REQ-015 A transfer on any VLD/RDY pair SHALL occur only in a cycle where both are high; VLD and payload SHALL hold until accepted.
REQ-016 FSM states IDLE, LOAD, SERVE; CFG_INFO_RDY SHALL be 1 only in IDLE.
REQ-017 IDLE SHALL go to LOAD (CFG_MODE=0) or SERVE (CFG_MODE=1) on a CFG handshake.
REQ-018 In LOAD, WRAM_WR_RDY SHALL be 1 and each accepted write SHALL store WRAM_WR_DAT at WRAM_WR_ADD; an accepted write with WRAM_WR_LST=1 SHALL return to IDLE next cycle.
REQ-019 Outside LOAD, WRAM_WR_RDY SHALL be 0; WRAM_ADD_RDY SHALL be 0 outside SERVE.
REQ-020 The read path SHALL be a 1-cycle synchronous RAM read feeding a 2-entry output FIFO; an address accepted in cycle N SHALL produce WRAM_DAT_VLD no earlier and, absent backpressure, no later than cycle N+2.
REQ-021 WRAM_ADD_RDY SHALL be SERVE && !lst_seen && ((fifo_occ + inflight) < 2 || (WRAM_DAT_VLD && WRAM_DAT_RDY)); FIFO SHALL never overflow.
REQ-022 With WRAM_DAT_RDY held 1, throughput SHALL be one read per cycle.
REQ-023 Responses SHALL return in request order; WRAM_DAT_LST SHALL equal the WRAM_ADD_LST of the corresponding request.
REQ-024 After accepting WRAM_ADD_LST=1, lst_seen SHALL set and no further addresses are accepted; FSM SHALL return to IDLE the cycle after the LST response handshake, clearing lst_seen.
REQ-025 STAT_RD_CNT SHALL clear on entry to SERVE, increment per response handshake, saturate at all-ones, and hold in IDLE/LOAD.
REQ-026 WRAM_DAT_DAT SHALL be 0 when WRAM_DAT_VLD is 0.
REQ-027 Reads of never-written addresses return undefined data; RAM contents are not reset.

Reset
REQ-028 On rst_n low: FSM to IDLE, FIFO and in-flight flushed, lst_seen cleared, STAT_RD_CNT 0; all VLD/RDY outputs 0 except CFG_INFO_RDY, which SHALL be 1 after release.
REQ-029 Reset mid-SERVE SHALL discard pending responses; no stale WRAM_DAT_VLD after release.

Structure
REQ-030 WRAM_ADD_AW, WRAM_DAT_DW, STAT_CNT_DW defaults and the FSM state encoding SHALL live in the shared accelerator package.
REQ-031 Storage SHALL be one sub-module, wram_sp (single-port synchronous RAM, write-over-read never simultaneous by FSM); FIFO and FSM inline.

Verification
REQ-032 LOAD 128 words data=addr^0x5A, addr 0..127, last with LST -> FSM IDLE, CFG_INFO_RDY=1.
REQ-033 SERVE, addresses 0..127 back-to-back, DAT_RDY=1 -> first VLD at N+2, 128 consecutive responses data=addr^0x5A, STAT_RD_CNT=128.
REQ-034 SERVE with random DAT_RDY (50%) and random ADD_VLD -> in-order data, no loss/duplication, ADD_RDY low whenever occ+inflight=2 and no pop.
REQ-035 Request address 7 with LST=1 -> response DAT_LST=1, ADD_RDY=0 afterward, IDLE one cycle after handshake.
REQ-036 Assert rst_n low with 2 responses pending -> after release DAT_VLD=0, STAT_RD_CNT=0, CFG_INFO_RDY=1; reload-free reread returns prior data.
REQ-037 WR_VLD=1 during SERVE -> WR_RDY=0, RAM unchanged.
